// File: rtl/axi_burst_splitter_ax_chan.sv
// axi_burst_splitter_ax_chan: splits one AXI AW/AR burst into len+1 single-beat INCR requests after allocating a per-ID beat counter
// Ports: clk_i/rst_i clock and sync active-high reset; ax_*_i/ax_ready_o upstream burst request;
// alloc_*_o/alloc_gnt_i counter allocation handshake; ax_*_o/ax_ready_i downstream single-beat requests; busy_o not idle.
module axi_burst_splitter_ax_chan #(
  parameter int AddrWidth = 32,
  parameter int IdWidth = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [IdWidth-1:0]   ax_id_i,
  input  logic [AddrWidth-1:0] ax_addr_i,
  input  logic [7:0]           ax_len_i,
  input  logic [2:0]           ax_size_i,
  input  logic [1:0]           ax_burst_i,
  input  logic                 ax_valid_i,
  output logic                 ax_ready_o,
  output logic [IdWidth-1:0]   alloc_id_o,
  output logic [7:0]           alloc_len_o,
  output logic                 alloc_req_o,
  input  logic                 alloc_gnt_i,
  output logic [IdWidth-1:0]   ax_id_o,
  output logic [AddrWidth-1:0] ax_addr_o,
  output logic [7:0]           ax_len_o,
  output logic [2:0]           ax_size_o,
  output logic [1:0]           ax_burst_o,
  output logic                 ax_valid_o,
  input  logic                 ax_ready_i,
  output logic                 busy_o
);
  typedef enum logic [1:0] {IDLE, ALLOC, ISSUE} state_e;
  state_e               state_q;
  logic [IdWidth-1:0]   id_q;
  logic [AddrWidth-1:0] start_q, cur_q, cur_d;
  logic [7:0]           len_q, cnt_q;
  logic [2:0]           size_q;
  logic [1:0]           burst_q;
  logic [AddrWidth-1:0] step, bnd, lo, inc;
  always_comb begin
    step  = AddrWidth'(1) << size_q;
    bnd   = AddrWidth'({1'b0, len_q} + 9'd1) << size_q;
    lo    = start_q & ~(bnd - AddrWidth'(1));
    inc   = (cur_q & ~(step - AddrWidth'(1))) + step;
    cur_d = burst_q == 2'b00 ? cur_q :
            (burst_q == 2'b10 && inc == lo + bnd) ? lo : inc;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      id_q    <= '0;
      start_q <= '0;
      cur_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (ax_valid_i) begin
          id_q    <= ax_id_i;
          start_q <= ax_addr_i;
          len_q   <= ax_len_i;
          size_q  <= ax_size_i;
          burst_q <= ax_burst_i;
          state_q <= ALLOC;
        end
        ALLOC: if (alloc_gnt_i) begin
          cnt_q   <= len_q;
          cur_q   <= start_q;
          state_q <= ISSUE;
        end
        ISSUE: if (ax_ready_i) begin
          if (cnt_q == 8'd0) state_q <= IDLE;
          else begin
            cnt_q <= cnt_q - 8'd1;
            cur_q <= cur_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  // Handshake/status outputs are masked by rst_i so they drop while reset is held.
  assign ax_ready_o  = !rst_i && state_q == IDLE;
  assign alloc_req_o = !rst_i && state_q == ALLOC;
  assign ax_valid_o  = !rst_i && state_q == ISSUE;
  assign busy_o      = !rst_i && state_q != IDLE;
  assign alloc_id_o  = id_q;
  assign alloc_len_o = len_q;
  assign ax_id_o     = id_q;
  assign ax_addr_o   = cur_q;
  assign ax_len_o    = 8'd0;
  assign ax_size_o   = size_q;
  assign ax_burst_o  = 2'b01;
endmodule
